age_issue_queue_2w1r: RTL

Age-ordered issue-queue buffer, second generation: accepts up to two dispatched instructions per cycle and issues the single oldest ready entry. Each entry holds a payload, per-operand condition bits, and a ROB id with a wrap bit. Condition bits are updated by ROB-id match over `WB_CH` parallel writeback channels. On rollback, the block performs a wrap-aware flush of all entries younger than the flush id. It sits between dispatch and the functional-unit issue ports in the backend ISU.

---
 rtl/age_iq_pkg.sv | 30 +++
 rtl/age_iq_entry.sv | 90 +++++++++
 rtl/age_issue_queue_2w1r.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/age_iq_pkg.sv
// Shared types, constants and helpers for the age-ordered issue queue.
// Contents: default field widths, iq_entry_t payload bundle, enqueue slot
// count and the wrap-aware ROB id age compare.
package age_iq_pkg;

   localparam int unsigned AGE_IQ_ENQ_W = 2;
   localparam int unsigned IQ_DATA_W    = 248;
   localparam int unsigned IQ_COND_W    = 2;
   localparam int unsigned IQ_ROBID_W   = 7;

   typedef struct packed {
      logic [IQ_DATA_W-1:0]  data;
      logic [IQ_COND_W-1:0]  cond;
      logic [IQ_ROBID_W-1:0] robid;
   } iq_entry_t;

   // True when ROB id a is younger than b; w is the id width, MSB is the wrap bit.
   function automatic logic robid_younger(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
      logic [31:0] idx_mask;
      logic        a_wrap;
      logic        b_wrap;
      idx_mask = (32'd1 << (w - 1)) - 32'd1;
      a_wrap   = ((a >> (w - 1)) & 32'd1) != 32'd0;
      b_wrap   = ((b >> (w - 1)) & 32'd1) != 32'd0;
      return (a_wrap == b_wrap) ? ((a & idx_mask) > (b & idx_mask))
                                : ((a & idx_mask) < (b & idx_mask));
   endfunction

endpackage

// File: rtl/age_iq_entry.sv
// One issue-queue entry: storage, per-channel condition merge and flush compare.
// Ports: alloc_* write a new entry, clear_i drops it on issue, upd_* merge
// condition bits by ROB id match, flush_* kill it when younger than the flush id.
// Outputs: valid_o, ready_o (valid and all cond set), kill_c_o (combinational
// flush hit this cycle), stored data/cond/robid.
module age_iq_entry
   import age_iq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = IQ_DATA_W,
   parameter int unsigned COND_WIDTH  = IQ_COND_W,
   parameter int unsigned ROBID_WIDTH = IQ_ROBID_W,
   parameter int unsigned WB_CH       = 2
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic                                  alloc_i,
   input  logic [DATA_WIDTH-1:0]                 alloc_data_i,
   input  logic [COND_WIDTH-1:0]                 alloc_cond_i,
   input  logic [ROBID_WIDTH-1:0]                alloc_robid_i,
   input  logic                                  clear_i,
   input  logic [WB_CH-1:0]                      upd_valid_i,
   input  logic [WB_CH-1:0][ROBID_WIDTH-1:0]     upd_robid_i,
   input  logic [WB_CH-1:0][COND_WIDTH-1:0]      upd_mask_i,
   input  logic [WB_CH-1:0][COND_WIDTH-1:0]      upd_value_i,
   input  logic                                  flush_valid_i,
   input  logic [ROBID_WIDTH-1:0]                flush_robid_i,
   output logic                                  valid_o,
   output logic                                  ready_o,
   output logic                                  kill_c_o,
   output logic [DATA_WIDTH-1:0]                 data_o,
   output logic [COND_WIDTH-1:0]                 cond_o,
   output logic [ROBID_WIDTH-1:0]                robid_o
);

   logic                   valid_q, valid_d;
   logic [DATA_WIDTH-1:0]  data_q,  data_d;
   logic [COND_WIDTH-1:0]  cond_q,  cond_d;
   logic [ROBID_WIDTH-1:0] robid_q, robid_d;
   logic [COND_WIDTH-1:0]  cond_upd;

   // Ascending channel order: a higher channel overrides overlapping mask bits.
   always_comb begin
      cond_upd = cond_q;
      for (int c = 0; c < int'(WB_CH); c++) begin
         if (upd_valid_i[c] && (upd_robid_i[c] == robid_q)) begin
            cond_upd = (cond_upd & ~upd_mask_i[c]) | (upd_value_i[c] & upd_mask_i[c]);
         end
      end
   end

   assign kill_c_o = valid_q && flush_valid_i &&
                     robid_younger(32'(robid_q), 32'(flush_robid_i), ROBID_WIDTH);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cond_d  = cond_q;
      robid_d = robid_q;
      if (alloc_i) begin
         valid_d = 1'b1;
         data_d  = alloc_data_i;
         cond_d  = alloc_cond_i;
         robid_d = alloc_robid_i;
      end else if (valid_q) begin
         cond_d = cond_upd;
         if (clear_i || kill_c_o) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cond_q  <= '0;
         robid_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cond_q  <= cond_d;
         robid_q <= robid_d;
      end
   end

   assign valid_o = valid_q;
   assign ready_o = valid_q && (&cond_q);
   assign data_o  = data_q;
   assign cond_o  = cond_q;
   assign robid_o = robid_q;

endmodule

// File: rtl/age_issue_queue_2w1r.sv
// Age-ordered issue queue: two dispatch slots per cycle, issues the single
// oldest ready entry, condition updates over WB_CH channels, wrap-aware flush.
// Ports: enq_* dispatch side (enq_ready needs two free entries, no flush),
// deq_* issue side (zero when deq_valid=0), upd_* writeback condition updates,
// flush_* rollback (keeps the entry equal to flush_robid), count occupancy.
// Optional macro AGE_IQ_ENQ_BYPASS_EN: same-cycle updates also patch enq_cond.
module age_issue_queue_2w1r
   import age_iq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = IQ_DATA_W,
   parameter int unsigned COND_WIDTH  = IQ_COND_W,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned ROBID_WIDTH = IQ_ROBID_W,
   parameter int unsigned WB_CH       = 2
) (
   input  logic                                       clock,
   input  logic                                       reset_n,
   input  logic [AGE_IQ_ENQ_W-1:0]                    enq_valid,
   input  logic [AGE_IQ_ENQ_W-1:0][DATA_WIDTH-1:0]    enq_data,
   input  logic [AGE_IQ_ENQ_W-1:0][COND_WIDTH-1:0]    enq_cond,
   input  logic [AGE_IQ_ENQ_W-1:0][ROBID_WIDTH-1:0]   enq_robid,
   output logic                                       enq_ready,
   output logic                                       deq_valid,
   input  logic                                       deq_ready,
   output logic [DATA_WIDTH-1:0]                      deq_data,
   output logic [COND_WIDTH-1:0]                      deq_cond,
   output logic [ROBID_WIDTH-1:0]                     deq_robid,
   input  logic [WB_CH-1:0]                           upd_valid,
   input  logic [WB_CH-1:0][ROBID_WIDTH-1:0]          upd_robid,
   input  logic [WB_CH-1:0][COND_WIDTH-1:0]           upd_mask,
   input  logic [WB_CH-1:0][COND_WIDTH-1:0]           upd_value,
   input  logic                                       flush_valid,
   input  logic [ROBID_WIDTH-1:0]                     flush_robid,
   output logic [$clog2(DEPTH+1)-1:0]                 count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]                  e_valid, e_ready, e_kill, alloc, alloc_slot, clear, sel, keep;
   logic [DEPTH-1:0][DATA_WIDTH-1:0]  e_data;
   logic [DEPTH-1:0][COND_WIDTH-1:0]  e_cond;
   logic [DEPTH-1:0][ROBID_WIDTH-1:0] e_robid;
   logic [DEPTH-1:0][DEPTH-1:0]       age_q, age_d;
   logic [CNT_W-1:0]                  count_q, count_d, free_cnt, n_enq, n_deq, n_kill;
   logic [IDX_W-1:0]                  idx0, idx1;
   logic                              found0, found1, enq_fire, enq_dual, deq_fire;
   logic [AGE_IQ_ENQ_W-1:0][COND_WIDTH-1:0] enq_cond_eff;

`ifdef AGE_IQ_ENQ_BYPASS_EN
   // Writebacks that race the dispatch of their target are folded into enq_cond.
   always_comb begin
      enq_cond_eff = enq_cond;
      for (int s = 0; s < int'(AGE_IQ_ENQ_W); s++) begin
         for (int c = 0; c < int'(WB_CH); c++) begin
            if (upd_valid[c] && (upd_robid[c] == enq_robid[s])) begin
               enq_cond_eff[s] = (enq_cond_eff[s] & ~upd_mask[c]) | (upd_value[c] & upd_mask[c]);
            end
         end
      end
   end
`else
   assign enq_cond_eff = enq_cond;
`endif

   // Lowest and second-lowest free entries, plus free count.
   always_comb begin
      free_cnt = '0;
      found0   = 1'b0;
      found1   = 1'b0;
      idx0     = '0;
      idx1     = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!e_valid[i]) begin
            free_cnt = free_cnt + CNT_W'(1);
            if (!found0) begin
               idx0   = IDX_W'(i);
               found0 = 1'b1;
            end else if (!found1) begin
               idx1   = IDX_W'(i);
               found1 = 1'b1;
            end
         end
      end
   end

   assign enq_ready = (free_cnt >= CNT_W'(2)) && !flush_valid;
   assign enq_fire  = enq_ready && (|enq_valid);
   assign enq_dual  = &enq_valid;

   // The older valid slot takes idx0; slot 1 takes idx1 only when both are valid.
   always_comb begin
      alloc      = '0;
      alloc_slot = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (enq_fire && (IDX_W'(i) == idx0)) begin
            alloc[i]      = 1'b1;
            alloc_slot[i] = !enq_valid[0];
         end else if (enq_fire && enq_dual && (IDX_W'(i) == idx1)) begin
            alloc[i]      = 1'b1;
            alloc_slot[i] = 1'b1;
         end
      end
   end

   // Oldest ready: no other ready entry is older than it.
   always_comb begin
      sel = e_ready;
      for (int i = 0; i < int'(DEPTH); i++) begin
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (e_ready[j] && age_q[j][i]) sel[i] = 1'b0;
         end
      end
   end

   assign deq_valid = (|sel) && !flush_valid;
   assign deq_fire  = deq_valid && deq_ready;
   assign clear     = deq_fire ? sel : '0;

   always_comb begin
      deq_data  = '0;
      deq_cond  = '0;
      deq_robid = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (deq_valid && sel[i]) begin
            deq_data  = deq_data  | e_data[i];
            deq_cond  = deq_cond  | e_cond[i];
            deq_robid = deq_robid | e_robid[i];
         end
      end
   end

   // Removed entries lose row/column; new entries are younger than all survivors.
   always_comb begin
      keep  = e_valid & ~clear & ~e_kill;
      age_d = age_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (!keep[i] || !keep[j]) age_d[i][j] = 1'b0;
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (alloc[i]) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
               age_d[i][j] = 1'b0;
               age_d[j][i] = keep[j];
            end
         end
      end
      if (enq_fire && enq_dual) age_d[idx0][idx1] = 1'b1;
   end

   always_comb begin
      n_kill = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (e_kill[i]) n_kill = n_kill + CNT_W'(1);
      end
      n_enq   = enq_fire ? (enq_dual ? CNT_W'(2) : CNT_W'(1)) : '0;
      n_deq   = deq_fire ? CNT_W'(1) : '0;
      count_d = count_q + n_enq - n_deq - n_kill;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         age_q   <= '0;
         count_q <= '0;
      end else begin
         age_q   <= age_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_entry
      age_iq_entry #(
         .DATA_WIDTH  (DATA_WIDTH),
         .COND_WIDTH  (COND_WIDTH),
         .ROBID_WIDTH (ROBID_WIDTH),
         .WB_CH       (WB_CH)
      ) u_entry (
         .clock         (clock),
         .reset_n       (reset_n),
         .alloc_i       (alloc[g]),
         .alloc_data_i  (enq_data[alloc_slot[g]]),
         .alloc_cond_i  (enq_cond_eff[alloc_slot[g]]),
         .alloc_robid_i (enq_robid[alloc_slot[g]]),
         .clear_i       (clear[g]),
         .upd_valid_i   (upd_valid),
         .upd_robid_i   (upd_robid),
         .upd_mask_i    (upd_mask),
         .upd_value_i   (upd_value),
         .flush_valid_i (flush_valid),
         .flush_robid_i (flush_robid),
         .valid_o       (e_valid[g]),
         .ready_o       (e_ready[g]),
         .kill_c_o      (e_kill[g]),
         .data_o        (e_data[g]),
         .cond_o        (e_cond[g]),
         .robid_o       (e_robid[g])
      );
   end

endmodule
